// File: rtl/hs_syn_arb_pkg.sv
// Shared types and helpers for the handshake-synchronizer channel scheduler.
package hs_syn_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitHi,
        StWaitLo,
        StGuard
    } state_e;

    localparam int unsigned GapW = 2;

    // Index width for a vector of `value` entries; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/hs_syn_arb_rr_arb.sv
// Combinational round-robin picker: first pending request at or after rrPtr wins.
module rr_arb
    import hs_syn_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rrPtr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int unsigned cand;
        logic [N_REQ-1:0] shifted;
        onehot  = '0;
        idx     = '0;
        any     = 1'b0;
        cand    = 0;
        shifted = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand    = (32'(rrPtr) + i) % N_REQ;
            shifted = req >> cand;
            if (!any && shifted[0]) begin
                any    = 1'b1;
                idx    = IDX_W'(cand);
                onehot = {{(N_REQ-1){1'b0}}, 1'b1} << cand;
            end
        end
    end

endmodule

// File: rtl/hs_syn_arb.sv
// Sender-domain scheduler sharing one level/pulse handshake synchronizer between N requesters.
module hs_syn_arb
    import hs_syn_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned TMO_W = 8,
    parameter int unsigned GAP   = 1,
    localparam int unsigned IdxW = clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] tmo,
    output logic             hs_in,
    input  logic             hs_busy,
    output logic [IdxW-1:0]  owner_id,
    output logic             active
);

    state_e           stateQ, stateD;
    logic [N_REQ-1:0] grantQ, grantD;
    logic [N_REQ-1:0] doneQ, doneD;
    logic [N_REQ-1:0] tmoQ, tmoD;
    logic             hsInQ, hsInD;
    logic [IdxW-1:0]  ownerQ, ownerD;
    logic [IdxW-1:0]  rrPtrQ, rrPtrD;
    logic [TMO_W-1:0] tmoCntQ, tmoCntD;
    logic [GapW-1:0]  gapCntQ, gapCntD;

    logic [N_REQ-1:0] arbOnehot;
    logic [IdxW-1:0]  arbIdx;
    logic             arbAny;
    logic             tmoHit;

    rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IdxW)
    ) uArb (
        .req    (req),
        .rrPtr  (rrPtrQ),
        .onehot (arbOnehot),
        .idx    (arbIdx),
        .any    (arbAny)
    );

    assign tmoHit = (tmoCntQ == {TMO_W{1'b1}});

    always_comb begin
        stateD  = stateQ;
        grantD  = grantQ;
        ownerD  = ownerQ;
        rrPtrD  = rrPtrQ;
        tmoCntD = tmoCntQ;
        gapCntD = gapCntQ;
        doneD   = '0;
        tmoD    = '0;
        unique case (stateQ)
            StIdle: begin
                // A busy channel here is a leftover handshake; never launch over it.
                if (arbAny && !hs_busy) begin
                    grantD = arbOnehot;
                    ownerD = arbIdx;
                    rrPtrD = (arbIdx == IdxW'(N_REQ - 1)) ? '0 : arbIdx + 1'b1;
                    stateD = StLaunch;
                end
            end
            StLaunch: begin
                tmoCntD = '0;
                stateD  = StWaitHi;
            end
            StWaitHi, StWaitLo: begin
                tmoCntD = tmoCntQ + 1'b1;
                if (stateQ == StWaitHi && hs_busy) begin
                    stateD = StWaitLo;
                end else if (stateQ == StWaitLo && !hs_busy) begin
                    doneD  = grantQ;
                    grantD = '0;
                    ownerD = '0;
                    if (GAP == 0) begin
                        stateD = StIdle;
                    end else begin
                        stateD  = StGuard;
                        gapCntD = '0;
                    end
                end else if (tmoHit) begin
                    tmoD   = grantQ;
                    grantD = '0;
                    ownerD = '0;
                    stateD = StIdle;
                end
            end
            StGuard: begin
                if (gapCntQ == GapW'(GAP - 1)) begin
                    stateD = StIdle;
                end else begin
                    gapCntD = gapCntQ + 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
        hsInD = (stateD == StLaunch);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= StIdle;
            grantQ  <= '0;
            doneQ   <= '0;
            tmoQ    <= '0;
            hsInQ   <= 1'b0;
            ownerQ  <= '0;
            rrPtrQ  <= '0;
            tmoCntQ <= '0;
            gapCntQ <= '0;
        end else begin
            stateQ  <= stateD;
            grantQ  <= grantD;
            doneQ   <= doneD;
            tmoQ    <= tmoD;
            hsInQ   <= hsInD;
            ownerQ  <= ownerD;
            rrPtrQ  <= rrPtrD;
            tmoCntQ <= tmoCntD;
            gapCntQ <= gapCntD;
        end
    end

    assign grant    = grantQ;
    assign done     = doneQ;
    assign tmo      = tmoQ;
    assign hs_in    = hsInQ;
    assign owner_id = ownerQ;
    assign active   = (stateQ != StIdle);

endmodule

// File: tb/tb_hs_syn_arb.sv
// Scoreboard bench for hs_syn_arb with a behavioural model of the synchronizer busy flag.
module tb_hs_syn_arb;

    localparam int N   = 4;
    localparam int TW  = 8;
    localparam int GP  = 1;
    localparam int K   = 6;
    localparam int LAT = K + 2;

    typedef struct {
        int idx;
        bit isTmo;
        int lat;
        int gap;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant, done, tmo;
    logic         hsIn, hsBusy;
    logic [1:0]   ownerId;
    logic         active;

    logic modelBusy = 1'b0;
    int   busyLeft  = 0;
    logic busyForce;

    int checks   = 0;
    int failures = 0;

    exp_t launchQ[$];
    exp_t endQ[$];

    hs_syn_arb #(
        .N_REQ (N),
        .TMO_W (TW),
        .GAP   (GP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .done     (done),
        .tmo      (tmo),
        .hs_in    (hsIn),
        .hs_busy  (hsBusy),
        .owner_id (ownerId),
        .active   (active)
    );

    always #5 clk = ~clk;

    // Synchronizer model: busy rises the cycle after hs_in and stays up K cycles.
    always @(posedge clk) begin
        if (hsIn) begin
            modelBusy <= 1'b1;
            busyLeft  <= K - 1;
        end else if (busyLeft > 0) begin
            busyLeft <= busyLeft - 1;
        end else begin
            modelBusy <= 1'b0;
        end
    end
    assign hsBusy = modelBusy | busyForce;

    task automatic check(input string name, input int act, input int req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
        end
    endtask

    function automatic int onehotOf(input int idx);
        return 1 << idx;
    endfunction

    task automatic push(input int idx, input bit isTmo, input int lat, input int gap);
        exp_t e;
        e.idx = idx; e.isTmo = isTmo; e.lat = lat; e.gap = gap;
        launchQ.push_back(e);
        endQ.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT launches or finishes a transaction.
    initial begin
        int   cyc;
        int   lastLaunch;
        logic prevHs;
        logic [N-1:0] prevEnd;
        exp_t e;
        cyc = 0; lastLaunch = 0; prevHs = 1'b0; prevEnd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (hsIn) begin
                check("hs_in_while_busy", int'(hsBusy), 0);
                check("hs_in_width", int'(prevHs), 0);
                if (launchQ.size() == 0) begin
                    check("unexpected_launch", 1, 0);
                end else begin
                    e = launchQ.pop_front();
                    check("launch_grant", int'(grant), onehotOf(e.idx));
                    check("launch_owner", int'(ownerId), e.idx);
                    check("launch_active", int'(active), 1);
                    if (e.gap >= 0) check("launch_interval", cyc - lastLaunch, e.gap);
                end
                lastLaunch = cyc;
            end
            if (done != '0 || tmo != '0) begin
                check("end_width", int'(prevEnd), 0);
                if (endQ.size() == 0) begin
                    check("unexpected_end", int'(done | tmo), 0);
                end else begin
                    e = endQ.pop_front();
                    check("end_done", int'(done), e.isTmo ? 0 : onehotOf(e.idx));
                    check("end_tmo", int'(tmo), e.isTmo ? onehotOf(e.idx) : 0);
                    check("end_latency", cyc - lastLaunch, e.lat);
                end
            end
            prevHs  = hsIn;
            prevEnd = done | tmo;
        end
    end

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitHsIn(input int limit);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            seen = hsIn;
        end
        check("wait_hs_in", int'(seen), 1);
    endtask

    task automatic waitEnd(input int limit);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            seen = (done != '0) || (tmo != '0);
        end
        check("wait_end", int'(seen), 1);
    endtask

    task automatic countHsIn(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (hsIn) cnt++;
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((launchQ.size() != 0 || endQ.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain", launchQ.size() + endQ.size(), 0);
    endtask

    initial begin
        int cnt;
        reset     = 1'b1;
        req       = '0;
        busyForce = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_done", int'(done), 0);
        check("rst_tmo", int'(tmo), 0);
        check("rst_hs_in", int'(hsIn), 0);
        check("rst_owner", int'(ownerId), 0);
        check("rst_active", int'(active), 0);
        reset = 1'b0;

        // Single requester.
        push(2, 1'b0, LAT, -1);
        req = 4'b0100;
        waitEnd(50);
        req = '0;
        drain(20);

        // All requesters held: rotation 0,1,2,3,0 at minimum interval.
        doReset();
        push(0, 1'b0, LAT, -1);
        push(1, 1'b0, LAT, 3 + GP + K);
        push(2, 1'b0, LAT, 3 + GP + K);
        push(3, 1'b0, LAT, 3 + GP + K);
        push(0, 1'b0, LAT, 3 + GP + K);
        req = 4'b1111;
        for (int t = 0; t < 5; t++) waitEnd(50);
        req = '0;
        drain(20);

        // Busy stuck high: timeout, then no launch until busy falls.
        doReset();
        push(3, 1'b1, 257, -1);
        req = 4'b1000;
        waitHsIn(20);
        busyForce = 1'b1;
        waitEnd(400);
        req = 4'b0001;
        countHsIn(30, cnt);
        check("no_launch_while_stuck", cnt, 0);
        push(0, 1'b0, LAT, -1);
        busyForce = 1'b0;
        waitEnd(50);
        req = '0;
        drain(20);

        // Busy already high at reset release.
        reset     = 1'b1;
        busyForce = 1'b1;
        req       = 4'b0001;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        countHsIn(20, cnt);
        check("no_launch_stale_busy", cnt, 0);
        push(0, 1'b0, LAT, -1);
        busyForce = 1'b0;
        waitEnd(50);
        req = '0;
        drain(20);

        // Reset in WAIT_LO: launch expected, completion must not be reported.
        doReset();
        begin
            exp_t e;
            e.idx = 2; e.isTmo = 1'b0; e.lat = 0; e.gap = -1;
            launchQ.push_back(e);
        end
        req = 4'b0100;
        waitHsIn(20);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        check("midrst_grant", int'(grant), 0);
        check("midrst_active", int'(active), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_tmo", int'(tmo), 0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        drain(5);

        // req[1] dropped in WAIT_LO still completes; req[3] is next after rr pointer 2.
        doReset();
        push(1, 1'b0, LAT, -1);
        req = 4'b0010;
        waitHsIn(20);
        repeat (2) @(negedge clk);
        push(3, 1'b0, LAT, 3 + GP + K);
        req = 4'b1001;
        waitEnd(50);
        waitEnd(50);
        req = '0;
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
